// File: rtl/key_press_emitter_pkg.sv
// Shared types and elaboration helpers for the key press emitter.
package key_emit_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    function automatic int ticks_per_ms(input int clk_hz);
        return clk_hz / 1000;
    endfunction

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_press_emitter_ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICKS-1, pulses ms_tick on the terminal count.
// pre_tick flags the cycle before ms_tick so callers can register on-time outputs.
module ms_tick_gen
    import key_emit_pkg::*;
#(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic ms_tick,
    output logic pre_tick
);

    localparam int CW = cnt_width(TICKS - 1);
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);
    localparam logic [CW-1:0] PRE  = CW'(TICKS - 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign ms_tick  = (cnt == LAST);
    assign pre_tick = (cnt == PRE);

endmodule

// File: rtl/key_press_emitter.sv
// Emits active-low key-style pulses (HOLD_MS low, GAP_MS high) per trig, queueing extra requests.
// Define KEY_PRESS_EMITTER_OVF_EN to add the sticky ovf flag for dropped requests.
module key_press_emitter
    import key_emit_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int HOLD_MS     = 20,
    parameter int GAP_MS      = 20,
    parameter int MAX_PENDING = 7,
    localparam int PW         = cnt_width(MAX_PENDING)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    output logic          raw_out,
    output logic          busy,
    output logic [PW-1:0] pending,
`ifdef KEY_PRESS_EMITTER_OVF_EN
    output logic          ovf,
`endif
    output logic          done
);

    // state   | meaning
    // IDLE    | raw_out high, waiting for trig
    // ACTIVE  | raw_out low for HOLD_MS ms
    // GAP     | raw_out high for GAP_MS ms, then replay a pending request or idle

    localparam int TICKS  = ticks_per_ms(CLK_HZ);
    localparam int MS_MAX = (HOLD_MS > GAP_MS) ? HOLD_MS : GAP_MS;
    localparam int MW     = cnt_width(MS_MAX);

    localparam logic [MW-1:0] HOLD_LAST = MW'(HOLD_MS - 1);
    localparam logic [MW-1:0] GAP_LAST  = MW'(GAP_MS - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

    state_t        state;
    logic [MW-1:0] ms_cnt;
    logic          ms_tick;
    logic          pre_tick;
    logic          hold_end;
    logic          gap_end;
    logic          enter;
    logic          queue_req;
    logic          full;

    always_comb begin
        hold_end  = (state == ACTIVE) && ms_tick && (ms_cnt == HOLD_LAST);
        gap_end   = (state == GAP) && ms_tick && (ms_cnt == GAP_LAST);
        enter     = ((state == IDLE) && trig) || hold_end || gap_end;
        // A trig on the dequeue edge is absorbed by the replay, so it never counts as queued.
        queue_req = trig && (state != IDLE) && !gap_end;
        full      = (pending == PEND_MAX);
    end

    ms_tick_gen #(
        .TICKS (TICKS)
    ) u_ms_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (enter || (state == IDLE)),
        .ms_tick  (ms_tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            raw_out <= 1'b1;
            busy    <= 1'b0;
            pending <= '0;
            done    <= 1'b0;
            ms_cnt  <= '0;
`ifdef KEY_PRESS_EMITTER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= (state == GAP) && pre_tick && (ms_cnt == GAP_LAST);

            if (enter || state == IDLE) begin
                ms_cnt <= '0;
            end else if (ms_tick) begin
                ms_cnt <= ms_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trig) begin
                        state   <= ACTIVE;
                        raw_out <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (hold_end) begin
                        state   <= GAP;
                        raw_out <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (trig || pending != '0) begin
                            state   <= ACTIVE;
                            raw_out <= 1'b0;
                            if (!trig) begin
                                pending <= pending - 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    raw_out <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase

            if (queue_req) begin
                if (!full) begin
                    pending <= pending + 1'b1;
                end
`ifdef KEY_PRESS_EMITTER_OVF_EN
                else begin
                    ovf <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_key_press_emitter.sv
// Scoreboard bench for key_press_emitter with TICKS=4, HOLD_MS=2, GAP_MS=1, MAX_PENDING=3.
module tb_key_press_emitter;

    localparam int PW = 2;
    localparam int N  = 72;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trig = 1'b0;
    logic          raw_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          done;
    logic          ovf_s;
    logic [7:0]    obs;

    key_press_emitter #(
        .CLK_HZ      (4000),
        .HOLD_MS     (2),
        .GAP_MS      (1),
        .MAX_PENDING (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .raw_out (raw_out),
        .busy    (busy),
        .pending (pending),
`ifdef KEY_PRESS_EMITTER_OVF_EN
        .ovf     (ovf_s),
`endif
        .done    (done)
    );

`ifndef KEY_PRESS_EMITTER_OVF_EN
    assign ovf_s = 1'b0;
`endif

    always #5 clk = ~clk;

    assign obs = {ovf_s, raw_out, busy, done, 4'(pending)};

    typedef struct {
        int         cyc;
        logic [7:0] v;
        logic [7:0] m;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    // Expected waveform per sampled cycle c (sampled #1 after edge c-1).
    logic e_raw [0:N-1];
    logic e_busy[0:N-1];
    logic e_done[0:N-1];
    int   e_pend[0:N-1];
    logic e_ovf [0:N-1];
    logic pat   [0:N-1];

    task automatic clear_exp();
        for (int c = 0; c < N; c++) begin
            e_raw[c] = 1'b1; e_busy[c] = 1'b0; e_done[c] = 1'b0;
            e_pend[c] = 0;   e_ovf[c] = 1'b0;  pat[c] = 1'b0;
        end
    endtask

    // A pulse started at edge s: low in cycles s+1..s+8, gap s+9..s+12, done in s+12.
    task automatic add_pulse(input int s);
        for (int k = 1; k <= 12; k++) begin
            e_busy[s+k] = 1'b1;
            if (k <= 8) e_raw[s+k] = 1'b0;
        end
        e_done[s+12] = 1'b1;
    endtask

    task automatic set_pend(input int a, input int b, input int v);
        for (int c = a; c <= b; c++) e_pend[c] = v;
    endtask

    task automatic push_exp(input int n);
        exp_t x;
        for (int c = 1; c <= n; c++) begin
            x.cyc = c;
            x.v   = {e_ovf[c], e_raw[c], e_busy[c], e_done[c], 4'(e_pend[c])};
`ifdef KEY_PRESS_EMITTER_OVF_EN
            x.m   = 8'hFF;
`else
            x.m   = 8'h7F;
`endif
            q.push_back(x);
        end
    endtask

    task automatic do_reset();
        trig = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        trig = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ovf_s, raw_out, busy, done, 4'(pending)} !== 8'b0100_0000) begin
            errors++;
            $display("FAIL reset_state obs=%b exp=%b", obs, 8'b0100_0000);
        end
        #1 rst = 1'b0;
        clear_exp();
        push_exp(4);
        for (int c = 0; c < 4; c++) begin
            trig = pat[c];
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL reset_idle cycle %0d obs=%b exp=%b", e.cyc, obs, e.v);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        clear_exp();
        pat[0] = 1'b1;
        add_pulse(0);
        push_exp(16);
        for (int c = 0; c < 16; c++) begin
            trig = pat[c];
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL single cycle %0d obs=%b exp=%b", e.cyc, obs, e.v);
            end
        end
        trig = 1'b0;
    endtask

    task automatic test_queue_one();
        do_reset();
        clear_exp();
        pat[0] = 1'b1; pat[3] = 1'b1;
        add_pulse(0); add_pulse(12);
        set_pend(4, 12, 1);
        push_exp(28);
        for (int c = 0; c < 28; c++) begin
            trig = pat[c];
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL queue_one cycle %0d obs=%b exp=%b", e.cyc, obs, e.v);
            end
        end
        trig = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        clear_exp();
        for (int c = 0; c <= 4; c++) pat[c] = 1'b1;
        for (int p = 0; p < 4; p++) add_pulse(12 * p);
        set_pend(2, 2, 1); set_pend(3, 3, 2); set_pend(4, 12, 3);
        set_pend(13, 24, 2); set_pend(25, 36, 1);
        for (int c = 5; c < N; c++) e_ovf[c] = 1'b1;
        push_exp(52);
        for (int c = 0; c < 52; c++) begin
            trig = pat[c];
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL saturate cycle %0d obs=%b exp=%b", e.cyc, obs, e.v);
            end
        end
        trig = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_exp();
        for (int c = 0; c <= 3; c++) pat[c] = 1'b1;
        pat[12] = 1'b1;
        for (int p = 0; p < 5; p++) add_pulse(12 * p);
        set_pend(2, 2, 1); set_pend(3, 3, 2); set_pend(4, 24, 3);
        set_pend(25, 36, 2); set_pend(37, 48, 1);
        push_exp(64);
        for (int c = 0; c < 64; c++) begin
            trig = pat[c];
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL back_to_back cycle %0d obs=%b exp=%b", e.cyc, obs, e.v);
            end
        end
        trig = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        clear_exp();
        pat[0] = 1'b1; pat[1] = 1'b1;
        add_pulse(0);
        set_pend(2, 12, 1);
        push_exp(5);
        for (int c = 0; c < 5; c++) begin
            trig = pat[c];
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL async_pre cycle %0d obs=%b exp=%b", e.cyc, obs, e.v);
            end
        end
        trig = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 8'b0100_0000) begin
            errors++;
            $display("FAIL async_reset obs=%b exp=%b", obs, 8'b0100_0000);
        end
        #1 rst = 1'b0;
        clear_exp();
        pat[1] = 1'b1;
        add_pulse(1);
        push_exp(16);
        for (int c = 0; c < 16; c++) begin
            trig = pat[c];
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL async_post cycle %0d obs=%b exp=%b", e.cyc, obs, e.v);
            end
        end
        trig = 1'b0;
    endtask

    task automatic test_held_trig();
        do_reset();
        clear_exp();
        pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1;
        add_pulse(0); add_pulse(12); add_pulse(24);
        set_pend(2, 2, 1); set_pend(3, 12, 2); set_pend(13, 24, 1);
        push_exp(40);
        for (int c = 0; c < 40; c++) begin
            trig = pat[c];
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL held_trig cycle %0d obs=%b exp=%b", e.cyc, obs, e.v);
            end
        end
        trig = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue_one();
        test_saturate();
        test_back_to_back();
        test_async_reset();
        test_held_trig();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
